// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the nibble serializer: FSM states, digit
// geometry and the digit value carried by the commit strobe.
package nibble_serializer_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int DATA_W     = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W      = 3;
  localparam int GAP_W      = 4;

  localparam logic [DIGIT_W-1:0] COMMIT_DIGIT = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    GAP_WAIT,
    COMMIT,
    FINISH
  } state_t;

  function automatic logic [DIGIT_W-1:0] top_digit(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: DIGIT_W];
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Load/data request side and digit-strobe/status side of the serializer.
interface nibble_serializer_if;
  import nibble_serializer_pkg::*;

  logic               Load;
  logic [DATA_W-1:0]  DataIn;
  logic               Ready;
  logic [DIGIT_W-1:0] DigitOut;
  logic               Submit;
  logic               Busy;
  logic               Done;

  modport master (
    output Load, DataIn,
    input  Ready, DigitOut, Submit, Busy, Done
  );

  modport slave (
    input  Load, DataIn,
    output Ready, DigitOut, Submit, Busy, Done
  );

endinterface

// File: rtl/nibble_serializer_gap_timer.sv
// Down-counting gap timer: start loads the gap length, expire_o marks the
// last idle cycle so the FSM can leave the gap on the following edge.
module gap_timer
  import nibble_serializer_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             expire_o
);

  logic [GAP_W-1:0] count_q, count_d;
  logic             active_q, active_d;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (start_i) begin
      active_d = (gap_i != '0);
      count_d  = (gap_i == '0) ? '0 : gap_i - GAP_W'(1);
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign expire_o = active_q && (count_q == '0);

endmodule

// File: rtl/nibble_serializer.sv
// Transmit end of the digit-entry protocol: eight nibble strobes, MSB first,
// separated by GAP idle cycles, then one commit strobe and a Done pulse.
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int GAP = 3
) (
  input logic               Clk,
  input logic               Reset,
  nibble_serializer_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_L      = GAP_W'(GAP);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [CNT_W-1:0]   digit_cnt_q;
  logic [DIGIT_W-1:0] digit_q;
  logic               submit_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  logic gap_start;
  logic gap_expire;

  assign gap_start = (state_q == STROBE) && (GAP_L != '0);

  gap_timer u_gap_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .start_i  (gap_start),
    .gap_i    (GAP_L),
    .expire_o (gap_expire)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      digit_cnt_q <= '0;
      digit_q     <= '0;
      submit_q    <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Load) begin
            shift_q     <= bus.DataIn;
            digit_q     <= top_digit(bus.DataIn);
            digit_cnt_q <= '0;
            submit_q    <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= STROBE;
          end
        end
        STROBE: begin
          // The shift register always advances here, so the next digit sits on top.
          shift_q <= shift_q << DIGIT_W;
          if (GAP_L != '0) begin
            submit_q <= 1'b0;
            state_q  <= GAP_WAIT;
          end else if (digit_cnt_q == LAST_DIGIT) begin
            digit_q  <= COMMIT_DIGIT;
            submit_q <= 1'b1;
            state_q  <= COMMIT;
          end else begin
            digit_q     <= shift_q[DATA_W-DIGIT_W-1 -: DIGIT_W];
            digit_cnt_q <= digit_cnt_q + CNT_W'(1);
            submit_q    <= 1'b1;
            state_q     <= STROBE;
          end
        end
        GAP_WAIT: begin
          if (gap_expire) begin
            submit_q <= 1'b1;
            if (digit_cnt_q == LAST_DIGIT) begin
              digit_q <= COMMIT_DIGIT;
              state_q <= COMMIT;
            end else begin
              digit_q     <= top_digit(shift_q);
              digit_cnt_q <= digit_cnt_q + CNT_W'(1);
              state_q     <= STROBE;
            end
          end
        end
        COMMIT: begin
          submit_q    <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          digit_cnt_q <= '0;
          state_q     <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.DigitOut = digit_q;
  assign bus.Submit   = submit_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: two instances (GAP=3 and GAP=0) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_nibble_serializer;
  import nibble_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serializer_if if0 ();
  nibble_serializer_if if1 ();

  nibble_serializer #(.GAP(3)) dut0 (.Clk(clk), .Reset(rst), .bus(if0.slave));
  nibble_serializer #(.GAP(0)) dut1 (.Clk(clk), .Reset(rst), .bus(if1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        o_ready [2];
  logic        o_submit[2];
  logic        o_busy  [2];
  logic        o_done  [2];
  logic [3:0]  o_digit [2];
  logic        i_load  [2];
  logic [31:0] i_data  [2];

  assign o_ready[0] = if0.Ready;    assign o_ready[1] = if1.Ready;
  assign o_submit[0] = if0.Submit;  assign o_submit[1] = if1.Submit;
  assign o_busy[0] = if0.Busy;      assign o_busy[1] = if1.Busy;
  assign o_done[0] = if0.Done;      assign o_done[1] = if1.Done;
  assign o_digit[0] = if0.DigitOut; assign o_digit[1] = if1.DigitOut;
  assign i_load[0] = if0.Load;      assign i_load[1] = if1.Load;
  assign i_data[0] = if0.DataIn;    assign i_data[1] = if1.DataIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: everything follows from the acceptance cycle t0.
  int          gaps   [2] = '{3, 0};
  logic        m_act  [2] = '{1'b0, 1'b0};
  int          m_t0   [2] = '{0, 0};
  logic [31:0] m_data [2] = '{32'h0, 32'h0};
  logic [3:0]  m_last [2] = '{4'h0, 4'h0};

  function automatic void exp_out(input int g, input logic [31:0] d, input int rel,
                                  input logic act, input logic [3:0] last,
                                  output logic rdy, output logic sub, output logic bsy,
                                  output logic dn, output logic [3:0] dig);
    int span;
    int idx;
    logic [31:0] dd;
    span = 8 * (g + 1);
    rdy = 1'b1; sub = 1'b0; bsy = 1'b0; dn = 1'b0; dig = last;
    if (act && rel >= 1 && rel <= span + 2) begin
      rdy = 1'b0;
      bsy = (rel <= span + 1);
      dn  = (rel == span + 2);
      if (rel <= span + 1 && ((rel - 1) % (g + 1)) == 0) begin
        sub = 1'b1;
        idx = (rel - 1) / (g + 1);
        dd  = d >> (28 - 4 * idx);
        dig = (idx < 8) ? dd[3:0] : 4'h0;
      end
    end
  endfunction

  int          sub_cyc0[$];
  logic [3:0]  sub_dig0[$];
  int          sub_cyc1[$];
  logic [3:0]  sub_dig1[$];
  int          done_cyc0 = -1;
  int          done_cyc1 = -1;

  // Behavioural digit-entry receiver looped back from dut0.
  logic [31:0] rx_acc = 32'h0;
  int          rx_cnt = 0;
  logic [31:0] rx_out = 32'h0;
  int          rx_valid_cyc = -1;

  always @(negedge clk) begin
    logic r, s, b, d;
    logic [3:0] g;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        r = 1'b1; s = 1'b0; b = 1'b0; d = 1'b0; g = 4'h0;
        m_act[i] = 1'b0;
        m_last[i] = 4'h0;
      end else begin
        exp_out(gaps[i], m_data[i], cyc - m_t0[i], m_act[i], m_last[i], r, s, b, d, g);
      end
      chk($sformatf("dut%0d Ready", i), 32'(o_ready[i]), 32'(r));
      chk($sformatf("dut%0d Submit", i), 32'(o_submit[i]), 32'(s));
      chk($sformatf("dut%0d Busy", i), 32'(o_busy[i]), 32'(b));
      chk($sformatf("dut%0d Done", i), 32'(o_done[i]), 32'(d));
      chk($sformatf("dut%0d DigitOut", i), 32'(o_digit[i]), 32'(g));
      if (s) m_last[i] = g;
      if (!rst && r && i_load[i]) begin
        m_act[i]  = 1'b1;
        m_t0[i]   = cyc;
        m_data[i] = i_data[i];
      end
    end
    if (if0.Submit) begin sub_cyc0.push_back(cyc); sub_dig0.push_back(if0.DigitOut); end
    if (if1.Submit) begin sub_cyc1.push_back(cyc); sub_dig1.push_back(if1.DigitOut); end
    if (if0.Done) done_cyc0 = cyc;
    if (if1.Done) done_cyc1 = cyc;
    if (rst) begin
      rx_acc = 32'h0;
      rx_cnt = 0;
    end else if (if0.Submit) begin
      if (rx_cnt == 8) begin
        rx_out       = rx_acc;
        rx_valid_cyc = cyc + 1;
        rx_cnt       = 0;
        rx_acc       = 32'h0;
      end else begin
        rx_acc = {rx_acc[27:0], if0.DigitOut};
        rx_cnt++;
      end
    end
  end

  task automatic clear_logs();
    sub_cyc0.delete(); sub_dig0.delete();
    sub_cyc1.delete(); sub_dig1.delete();
    done_cyc0 = -1; done_cyc1 = -1;
  endtask

  task automatic do_load(input int which, input logic [31:0] data, output int lc);
    @(posedge clk); #1;
    if (which == 0) begin if0.Load = 1'b1; if0.DataIn = data; end
    else            begin if1.Load = 1'b1; if1.DataIn = data; end
    lc = cyc;
    @(posedge clk); #1;
    if (which == 0) begin if0.Load = 1'b0; if0.DataIn = $urandom; end
    else            begin if1.Load = 1'b0; if1.DataIn = $urandom; end
  endtask

  // Literal timing for a GAP=3 transfer loaded in cycle lc.
  task automatic check_g3(input string name, input int lc, input logic [31:0] data);
    logic [35:0] digs;
    digs = {data, 4'h0};
    chk({name, " strobe count"}, 32'(sub_cyc0.size()), 32'd9);
    for (int k = 0; k < 9 && k < sub_cyc0.size(); k++) begin
      chk($sformatf("%s strobe%0d cycle", name, k), 32'(sub_cyc0[k] - lc), 32'(1 + 4 * k));
      chk($sformatf("%s strobe%0d digit", name, k), 32'(sub_dig0[k]), 32'(digs[35 - 4 * k -: 4]));
    end
    chk({name, " done cycle"}, 32'(done_cyc0 - lc), 32'd34);
  endtask

  initial begin
    int lc;
    logic [35:0] digs;
    if0.Load = 1'b0; if0.DataIn = 32'h0;
    if1.Load = 1'b0; if1.DataIn = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // GAP=3 basic transfer
    clear_logs();
    do_load(0, 32'h12345678, lc);
    repeat (40) @(posedge clk); #1;
    check_g3("basic", lc, 32'h12345678);

    // GAP=0 back-to-back strobes
    clear_logs();
    do_load(1, 32'hA5F00F5A, lc);
    repeat (15) @(posedge clk); #1;
    digs = {32'hA5F00F5A, 4'h0};
    chk("gap0 strobe count", 32'(sub_cyc1.size()), 32'd9);
    for (int k = 0; k < 9 && k < sub_cyc1.size(); k++) begin
      chk($sformatf("gap0 strobe%0d cycle", k), 32'(sub_cyc1[k] - lc), 32'(1 + k));
      chk($sformatf("gap0 strobe%0d digit", k), 32'(sub_dig1[k]), 32'(digs[35 - 4 * k -: 4]));
    end
    chk("gap0 done cycle", 32'(done_cyc1 - lc), 32'd10);

    // Load during 4th gap and on the FINISH cycle are both ignored
    clear_logs();
    do_load(0, 32'h12345678, lc);
    while (cyc < lc + 14) begin @(posedge clk); #1; end
    if0.Load = 1'b1; if0.DataIn = 32'hFFFFFFFF;
    @(posedge clk); #1;
    if0.Load = 1'b0;
    while (cyc < lc + 34) begin @(posedge clk); #1; end
    if0.Load = 1'b1; if0.DataIn = 32'hFFFFFFFF;
    @(posedge clk); #1;
    if0.Load = 1'b0;
    repeat (10) @(posedge clk); #1;
    check_g3("busy load", lc, 32'h12345678);

    // Reset during the 3rd strobe discards the transfer
    clear_logs();
    do_load(0, 32'h12345678, lc);
    while (cyc < lc + 9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("reset Submit immediate", 32'(if0.Submit), 32'd0);
    chk("reset Ready immediate", 32'(if0.Ready), 32'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (40) @(posedge clk); #1;
    chk("post-reset strobes", 32'(sub_cyc0.size()), 32'd0);
    chk("post-reset Ready", 32'(if0.Ready), 32'd1);

    // Loopback into the digit-entry receiver
    clear_logs();
    do_load(0, 32'hDEAD1234, lc);
    repeat (40) @(posedge clk); #1;
    chk("loopback value", rx_out, 32'hDEAD1234);
    chk("loopback valid cycle", 32'(rx_valid_cyc - lc), 32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The module SHALL have parameter GAP, default 3, which sets the number of idle cycles between consecutive Submit strobes (legal range 0..15).
REQ-002 The module SHALL have port Clk, input, width 1, the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port Reset, input, width 1, an asynchronous active-high reset.
REQ-004 The module SHALL have port Load, input, width 1, a request to start sending DataIn.
REQ-005 The module SHALL have port DataIn, input, width 32: ID in [31:16], password in [15:0], most significant nibble first.
REQ-006 The module SHALL have port Ready, output, width 1, high only in IDLE, meaning Load will be accepted.
REQ-007 The module SHALL have port DigitOut, output, width 4, the digit currently presented.
REQ-008 The module SHALL have port Submit, output, width 1, a one-cycle strobe qualifying DigitOut.
REQ-009 The module SHALL have port Busy, output, width 1, high from Load acceptance until Done.
REQ-010 The module SHALL have port Done, output, width 1, a one-cycle pulse when the transfer is complete.

Function
REQ-011 The module SHALL act as the transmit end of the digit-entry protocol: 8 digit strobes followed by 1 commit strobe, which the receiving 32-bit digit-entry register needs to raise its valid output.
REQ-012 The FSM SHALL have states IDLE, STROBE, GAP_WAIT, COMMIT and FINISH.
REQ-013 Load SHALL be accepted only on an edge where Ready=1; the module SHALL capture DataIn into a shift register and go to STROBE.
REQ-014 In STROBE the module SHALL drive Submit=1 for exactly one cycle, with DigitOut set to the current top nibble, starting with DataIn[31:28] and ending with DataIn[3:0].
REQ-015 After each strobe the module SHALL go to GAP_WAIT for GAP cycles, then to STROBE again; when GAP=0 it SHALL skip GAP_WAIT and produce back-to-back strobes.
REQ-016 A 3-bit digit counter SHALL count strobes 0..7; after strobe 7 and its gap, the FSM SHALL go to COMMIT.
REQ-017 COMMIT SHALL drive Submit=1 for one cycle with DigitOut=4'h0, then go to FINISH.
REQ-018 FINISH SHALL last one cycle with Done=1 and Busy=0, then return to IDLE.
REQ-019 Latency SHALL be: first Submit in the cycle after acceptance; commit strobe 8*(GAP+1) cycles after the first Submit; Done in the cycle after the commit strobe.
REQ-020 DigitOut SHALL hold its value during GAP_WAIT; in IDLE and FINISH it SHALL hold the last driven value.
REQ-021 Submit SHALL never be high on two consecutive cycles, except when GAP=0.
REQ-022 Load while Busy=1 SHALL be ignored, with no effect on data, counter or timing.
REQ-023 Load on the FINISH cycle SHALL be ignored; Ready returns on the next cycle.
REQ-024 Changes to DataIn after acceptance SHALL NOT affect the transfer in progress.

Reset
REQ-025 When Reset is asserted, at any time including mid-transfer, the module SHALL immediately go to IDLE with DigitOut=0, Submit=0, Done=0, Busy=0, Ready=1, counters=0 and the shift register=0.
REQ-026 A transfer interrupted by reset SHALL be discarded, not resumed.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, NUM_DIGITS=8, DIGIT_W=4 and COMMIT_DIGIT=4'h0.
REQ-028 The gap counter SHALL be a sub-module named gap_timer, with start, GAP load and expire pulse.
REQ-029 The FSM, digit counter and shift register SHALL stay in nibble_serializer.

Verification
REQ-030 GAP=3, Load with DataIn=32'h12345678: Submit SHALL occur at cycles 1,5,9,...,29 with digits 1..8, commit at cycle 33 with 0, and Done at cycle 34.
REQ-031 GAP=0, DataIn=32'hA5F00F5A: nine consecutive Submit cycles SHALL carry A,5,F,0,0,F,5,A,0, followed by Done.
REQ-032 Load pulsed with 32'hFFFFFFFF during the 4th gap of a 32'h12345678 transfer: the output digit sequence SHALL be unchanged and Ready=0 throughout.
REQ-033 Reset asserted at the 3rd strobe: all outputs SHALL go to reset values in the same cycle; after release Ready=1 and no further Submit SHALL occur.
REQ-034 Loopback into the digit-entry register with DataIn=32'hDEAD1234: the register output SHALL equal 32'hDEAD1234 with its valid pulse one cycle after the commit strobe.
